// File: rtl/silife_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : silife_step_scheduler
//  Purpose  : Paces SiLife grid generations (free-run / single-step) and
//             requests exactly one MAX7219 frame after each generation.
//  Revision : 1.0  initial release
// ============================================================================
module silife_step_scheduler #(
    parameter int PERIOD_W = 16,
    parameter int GEN_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_run,
    input  logic                i_step,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_wr_active,
    input  logic                i_disp_enable,
    input  logic                i_disp_busy,
    output logic                o_grid_enable,
    output logic                o_disp_frame,
    output logic [GEN_W-1:0]    o_gen_count,
    output logic                o_idle
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DELAY = 3'd1,
        ST_SYNC  = 3'd2,
        ST_STEP  = 3'd3,
        ST_FRAME = 3'd4,
        ST_DRAIN = 3'd5
    } state_t;

    localparam logic [PERIOD_W-1:0] C_CNT_MAX = {PERIOD_W{1'b1}};

    state_t              r_state;
    state_t              w_next_state;
    state_t              w_post_target;
    logic [PERIOD_W-1:0] r_cnt;
    logic [GEN_W-1:0]    r_gen_count;
    logic                r_step_pending;
    logic                r_step_prev;
    logic                w_step_edge;
    logic                w_step_req;

    assign w_step_edge   = i_step & ~r_step_prev;
    assign w_step_req    = r_step_pending | w_step_edge;
    // i_run is sampled on leaving the generation, so a mid-sequence drop still finishes it
    assign w_post_target = i_run ? ST_DELAY : ST_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_step_req) begin
                    w_next_state = ST_SYNC;
                end else if (i_run) begin
                    w_next_state = ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (w_step_req) begin
                    w_next_state = ST_SYNC;
                end else if (!i_run) begin
                    w_next_state = ST_IDLE;
                end else if (r_cnt >= i_period) begin
                    w_next_state = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (!i_wr_active && !(i_disp_enable && i_disp_busy)) begin
                    w_next_state = ST_STEP;
                end
            end
            ST_STEP: begin
                w_next_state = i_disp_enable ? ST_FRAME : w_post_target;
            end
            ST_FRAME: begin
                if (i_disp_busy) begin
                    w_next_state = ST_DRAIN;
                end else if (!i_disp_enable) begin
                    w_next_state = w_post_target;
                end
            end
            ST_DRAIN: begin
                if (!i_disp_busy || !i_disp_enable) begin
                    w_next_state = w_post_target;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Delay counter restarts on every entry into DELAY and saturates at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if ((r_state != ST_DELAY) && (w_next_state == ST_DELAY)) begin
            r_cnt <= '0;
        end else if ((r_state == ST_DELAY) && (r_cnt != C_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Clearing on STEP entry wins so that an edge arriving on that same cycle is merged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_pending <= 1'b0;
            r_step_prev    <= 1'b0;
        end else begin
            r_step_prev <= i_step;
            if ((r_state != ST_STEP) && (w_next_state == ST_STEP)) begin
                r_step_pending <= 1'b0;
            end else if (w_step_edge) begin
                r_step_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gen_count <= '0;
        end else if (r_state == ST_STEP) begin
            r_gen_count <= r_gen_count + 1'b1;
        end
    end

    assign o_grid_enable = (r_state == ST_STEP);
    assign o_disp_frame  = (r_state == ST_FRAME);
    assign o_idle        = (r_state == ST_IDLE);
    assign o_gen_count   = r_gen_count;

endmodule
`default_nettype wire
